// File: rtl/operand_read_if.sv
// Decode-side, execute-side and writeback signals of the operand read stage.
// master = upstream/driver side, slave = the operand_read stage itself.
interface operand_read_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_rs1;
  logic [AW-1:0] in_rs2;
  logic [AW-1:0] in_rd;
  logic [1:0]    in_op;

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_a;
  logic [DW-1:0] out_b;
  logic [AW-1:0] out_rd;
  logic [1:0]    out_op;

  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_op, out_ready,
           wb_valid, wb_addr, wb_data,
    input  in_ready, out_valid, out_a, out_b, out_rd, out_op
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_op, out_ready,
           wb_valid, wb_addr, wb_data,
    output in_ready, out_valid, out_a, out_b, out_rd, out_op
  );
endinterface

// File: rtl/operand_read.sv
// Register-read stage: regfile, busy scoreboard with writeback bypass,
// and a single output register toward execute.
module operand_read #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input logic            clk,
  input logic            rst,
  operand_read_if.slave  bus
);

  logic [DW-1:0]    regs [NREGS];
  logic [NREGS-1:0] busy;

  logic          out_valid_q;
  logic [DW-1:0] out_a_q;
  logic [DW-1:0] out_b_q;
  logic [AW-1:0] out_rd_q;
  logic [1:0]    out_op_q;

  logic          wb_en;
  logic          byp_a;
  logic          byp_b;
  logic          wb_hit_rd;
  logic          hazard;
  logic          ready_c;
  logic          accept;
  logic [DW-1:0] rd_a;
  logic [DW-1:0] rd_b;

  // A bypass match implies a nonzero source because wb_en excludes address 0.
  always_comb begin
    wb_en     = bus.wb_valid && (bus.wb_addr != '0);
    byp_a     = wb_en && (bus.wb_addr == bus.in_rs1);
    byp_b     = wb_en && (bus.wb_addr == bus.in_rs2);
    wb_hit_rd = wb_en && (bus.wb_addr == bus.in_rd);

    rd_a = '0;
    if (byp_a)
      rd_a = bus.wb_data;
    else if (bus.in_rs1 != '0)
      rd_a = regs[bus.in_rs1];

    rd_b = '0;
    if (byp_b)
      rd_b = bus.wb_data;
    else if (bus.in_rs2 != '0)
      rd_b = regs[bus.in_rs2];

    hazard = ((bus.in_rs1 != '0) && busy[bus.in_rs1] && !byp_a) ||
             ((bus.in_rs2 != '0) && busy[bus.in_rs2] && !byp_b) ||
             ((bus.in_rd  != '0) && busy[bus.in_rd]  && !wb_hit_rd);

    ready_c = !hazard && (!out_valid_q || bus.out_ready);
    accept  = bus.in_valid && ready_c;
  end

  // The accept's busy set comes after the writeback clear so that set wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
      busy        <= '0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_rd_q    <= '0;
      out_op_q    <= '0;
    end else begin
      if (wb_en) begin
        regs[bus.wb_addr] <= bus.wb_data;
        busy[bus.wb_addr] <= 1'b0;
      end
      if (accept) begin
        out_valid_q <= 1'b1;
        out_a_q     <= rd_a;
        out_b_q     <= rd_b;
        out_rd_q    <= bus.in_rd;
        out_op_q    <= bus.in_op;
        if (bus.in_rd != '0)
          busy[bus.in_rd] <= 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_a     = out_a_q;
  assign bus.out_b     = out_b_q;
  assign bus.out_rd    = out_rd_q;
  assign bus.out_op    = out_op_q;

endmodule

// File: tb/tb_operand_read.sv
// Self-checking bench for operand_read: scoreboard of expected operand
// bundles checked when execute consumes them, plus per-scenario checks.
module tb_operand_read;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  operand_read_if #(.AW(5), .DW(32)) bus ();
  operand_read #(.NREGS(32), .AW(5), .DW(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [1:0]  op;
  } exp_t;

  exp_t        sb[$];
  exp_t        got;
  exp_t        want;
  logic [31:0] model [32];
  int          checks = 0;
  int          errors = 0;

  // Reference regfile, updated on the same edges as the design.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (bus.wb_valid && bus.wb_addr != 5'd0) begin
      model[bus.wb_addr] = bus.wb_data;
    end
  end

  // Scoreboard consumer: one comparison per output handshake.
  always @(negedge clk) begin
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      checks++;
      got = {bus.out_a, bus.out_b, bus.out_rd, bus.out_op};
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got a=%h b=%h rd=%0d op=%0d, required no output",
                 got.a, got.b, got.rd, got.op);
      end else begin
        want = sb.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL sb_data: got a=%h b=%h rd=%0d op=%0d, required a=%h b=%h rd=%0d op=%0d",
                   got.a, got.b, got.rd, got.op, want.a, want.b, want.rd, want.op);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic [4:0] addr, input logic [31:0] data);
    bus.wb_valid = 1'b1;
    bus.wb_addr  = addr;
    bus.wb_data  = data;
  endtask

  task automatic clear_wb();
    bus.wb_valid = 1'b0;
  endtask

  task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
    set_wb(addr, data);
    step();
    clear_wb();
  endtask

  function automatic logic [31:0] opnd(input logic [4:0] r);
    if (r == 5'd0) return 32'h0;
    if (bus.wb_valid && bus.wb_addr == r) return bus.wb_data;
    return model[r];
  endfunction

  task automatic present(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [1:0] op);
    bus.in_valid = 1'b1;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_rd    = rd;
    bus.in_op    = op;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [1:0] op,
                       input int max_wait, input string tag);
    bit   done = 1'b0;
    exp_t e;
    present(rs1, rs2, rd, op);
    for (int n = 0; n <= max_wait && !done; n++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        e = {opnd(rs1), opnd(rs2), rd, op};
        sb.push_back(e);
        done = 1'b1;
      end
      step();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_accept: in_ready stayed 0 for %0d cycles, required acceptance",
               tag, max_wait + 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_rs1 = 5'd0; bus.in_rs2 = 5'd0;
    bus.in_rd = 5'd0; bus.in_op = 2'd0;
    bus.out_ready = 1'b1;
    clear_wb(); bus.wb_addr = 5'd0; bus.wb_data = 32'h0;
    repeat (2) step();
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
    end
    checks++;
    if ({bus.out_a, bus.out_b, bus.out_rd, bus.out_op} !== 71'd0) begin
      errors++;
      $display("FAIL reset_out_regs: got a=%h b=%h rd=%0d op=%0d, required all 0",
               bus.out_a, bus.out_b, bus.out_rd, bus.out_op);
    end
    step();
  endtask

  task automatic test_basic();
    issue(5'd3, 5'd4, 5'd5, 2'd1, 0, "basic");
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL basic_latency: out_valid got %b, required 1", bus.out_valid);
    end
    step();
  endtask

  task automatic test_raw();
    exp_t e;
    present(5'd5, 5'd0, 5'd6, 2'd2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL raw_stall: in_ready got %b, required 0 (cycle %0d)", bus.in_ready, i);
      end
      step();
    end
    set_wb(5'd5, 32'hAA);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL raw_release: in_ready got %b, required 1", bus.in_ready);
    end else begin
      e = {32'hAA, 32'h0, 5'd6, 2'd2};
      sb.push_back(e);
    end
    step();
    bus.in_valid = 1'b0;
    clear_wb();
    wb_write(5'd6, 32'h66);
  endtask

  task automatic test_wb_read();
    wb_write(5'd7, 32'h1234);
    issue(5'd7, 5'd0, 5'd8, 2'd0, 0, "wb_read");
    set_wb(5'd10, 32'hBEEF);
    issue(5'd10, 5'd7, 5'd0, 2'd1, 0, "bypass");
    clear_wb();
    wb_write(5'd8, 32'h88);
  endtask

  task automatic test_reg0();
    wb_write(5'd0, 32'hFFFF);
    issue(5'd0, 5'd0, 5'd0, 2'd3, 0, "reg0_read");
    issue(5'd1, 5'd0, 5'd0, 2'd2, 0, "rd0_writer");
    issue(5'd0, 5'd0, 5'd11, 2'd3, 0, "reg0_reader");
    wb_write(5'd11, 32'hB);
  endtask

  task automatic test_backpressure();
    exp_t e;
    wb_write(5'd1, 32'h11);
    wb_write(5'd2, 32'h22);
    bus.out_ready = 1'b0;
    issue(5'd1, 5'd2, 5'd12, 2'd1, 0, "bp_first");
    present(5'd3, 5'd4, 5'd13, 2'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
          {bus.out_a, bus.out_b, bus.out_rd, bus.out_op} !== {32'h11, 32'h22, 5'd12, 2'd1}) begin
        errors++;
        $display("FAIL bp_hold: in_ready=%b out_valid=%b a=%h b=%h rd=%0d op=%0d, required 0 1 11 22 12 1",
                 bus.in_ready, bus.out_valid, bus.out_a, bus.out_b, bus.out_rd, bus.out_op);
      end
      step();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: in_ready got %b, required 1", bus.in_ready);
    end else begin
      e = {32'h0, 32'h0, 5'd13, 2'd2};
      sb.push_back(e);
    end
    step();
    bus.in_valid = 1'b0;
    wb_write(5'd12, 32'hC);
    wb_write(5'd13, 32'hD);
  endtask

  task automatic test_set_wins();
    exp_t e;
    set_wb(5'd9, 32'h99);
    issue(5'd0, 5'd0, 5'd9, 2'd0, 0, "setwin_issue");
    clear_wb();
    present(5'd9, 5'd0, 5'd0, 2'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL setwin_busy: in_ready got %b, required 0", bus.in_ready);
      end
      step();
    end
    set_wb(5'd9, 32'h77);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL setwin_release: in_ready got %b, required 1", bus.in_ready);
    end else begin
      e = {32'h77, 32'h0, 5'd0, 2'd1};
      sb.push_back(e);
    end
    step();
    bus.in_valid = 1'b0;
    clear_wb();
  endtask

  task automatic test_back_to_back();
    logic [4:0] tbl [5];
    tbl[0] = 5'd1; tbl[1] = 5'd2; tbl[2] = 5'd7; tbl[3] = 5'd9; tbl[4] = 5'd10;
    for (int i = 0; i < 6; i++)
      issue(tbl[i % 5], tbl[(i + 1) % 5], 5'd0, 2'(i), 0, "b2b");
    step();
  endtask

  task automatic test_reset_mid_stall();
    exp_t e;
    issue(5'd0, 5'd0, 5'd14, 2'd0, 0, "rms_issue");
    bus.out_ready = 1'b0;
    present(5'd14, 5'd0, 5'd0, 2'd1);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL rms_stall: in_ready got %b, required 0", bus.in_ready);
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL rms_out_valid: got %b, required 0", bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL rms_busy_cleared: in_ready got %b, required 1", bus.in_ready);
    end
    step();
    bus.out_ready = 1'b1;
    present(5'd1, 5'd14, 5'd0, 2'd3);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL rms_read_accept: in_ready got %b, required 1", bus.in_ready);
    end else begin
      e = {32'h0, 32'h0, 5'd0, 2'd3};
      sb.push_back(e);
    end
    step();
    bus.in_valid = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_raw();
    test_wb_read();
    test_reg0();
    test_backpressure();
    test_set_wins();
    test_back_to_back();
    test_reset_mid_stall();
    repeat (3) step();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_leftover: %0d outputs never produced, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
